interrupt_controller: RTL

- Collects external interrupt lines, latches rising edges as pending events, and selects one by fixed priority.
- Runs the request/acknowledge/return handshake with the CPU core.
- Supplies the interrupt ID that the INTID instruction writes to the destination register.
- Sits between peripheral interrupt sources and the CPU; the CPU takes the interrupt at an instruction boundary and ends service with RETI.

---
 rtl/interrupt_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: rising-edge capture into pending bits, enable mask,
// and the REQ/ack/SERVICE/RETI handshake. Define INTCTRL_SYNC_EN for 2-flop input synchronizers.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no request outstanding; picks lowest eligible line when any
// ST_REQ     | int_req high, int_id frozen until the CPU acknowledges
// ST_SERVICE | CPU is servicing int_id; waits for reti, no nesting

module interrupt_controller #(
    parameter int NUM_INT  = 8,
    parameter int INT_ID_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_INT-1:0]  int_in,
    input  logic                mask_we,
    input  logic [NUM_INT-1:0]  mask_wdata,
    output logic [NUM_INT-1:0]  mask_rdata,
    input  logic                int_ack,
    input  logic                reti,
    output logic                int_req,
    output logic [INT_ID_W-1:0] int_id,
    output logic                in_service,
    output logic [NUM_INT-1:0]  pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_INT-1:0]    in_s;
    logic [NUM_INT-1:0]    prev_q, prev_d;
    logic [NUM_INT-1:0]    pending_q, pending_d;
    logic [NUM_INT-1:0]    mask_q, mask_d;
    logic [INT_ID_W-1:0]   int_id_q, int_id_d;
    logic                  int_req_q, int_req_d;
    logic                  in_service_q, in_service_d;

    logic [NUM_INT-1:0]    rise;
    logic [NUM_INT-1:0]    eligible;
    logic [NUM_INT-1:0]    clr;
    logic [INT_ID_W-1:0]   sel_id;
    logic                  sel_valid;

`ifdef INTCTRL_SYNC_EN
    logic [NUM_INT-1:0] sync1_q, sync1_d;
    logic [NUM_INT-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = int_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = int_in;
`endif

    // Edge history, pending events and mask
    always_comb begin
        rise     = in_s & ~prev_q;
        prev_d   = in_s;
        eligible = pending_q & mask_q;
        mask_d   = mask_we ? mask_wdata : mask_q;

        // Walk downward so the lowest eligible index is the last one assigned.
        sel_valid = |eligible;
        sel_id    = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = INT_ID_W'(i);
            end
        end

        clr = '0;
        if (state_q == ST_REQ && int_ack) begin
            for (int i = 0; i < NUM_INT; i++) begin
                if (INT_ID_W'(i) == int_id_q) begin
                    clr[i] = 1'b1;
                end
            end
        end

        // A new edge on the bit being acknowledged survives the clear.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d  = ST_REQ;
                    int_id_d = sel_id;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (reti) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        int_req_d    = (state_d == ST_REQ);
        in_service_d = (state_d == ST_SERVICE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '1;
            pending_q    <= '0;
            mask_q       <= '0;
            int_id_q     <= '0;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            int_id_q     <= int_id_d;
            int_req_q    <= int_req_d;
            in_service_q <= in_service_d;
        end
    end

    assign mask_rdata = mask_q;
    assign pending    = pending_q;
    assign int_id     = int_id_q;
    assign int_req    = int_req_q;
    assign in_service = in_service_q;

endmodule
